// File: rtl/cmd_bus_master.sv
// Byte-stream command parser that issues single-cycle core bus accesses and streams back framed responses.
// Optional receive-stall timeout is enabled by defining CMD_BUS_MASTER_TIMEOUT_EN.
module cmd_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        cs,
  output logic        we,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        error
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_EOC, DISCARD, BUS_ACCESS, SEND_RESP
  } state_t;

  state_t      state;
  logic        wr;
  logic [1:0]  dcnt;
  logic [3:0]  idx;
  logic [3:0]  len;
  logic [7:0]  code;
  logic [31:0] rdata;
  logic        rx_take;
  logic        tx_take;

`ifdef CMD_BUS_MASTER_TIMEOUT_EN
  logic [31:0] tmo;
`endif

  always_comb begin
    rx_take = rx_valid && rx_ready;
    tx_take = tx_valid && tx_ready;
  end

  // Response layout: SOR, code, [addr, [D3..D0]], EOR; EOR is always the last of len bytes.
  function automatic logic [7:0] resp_byte(input logic [3:0] i, input logic [3:0] n,
                                           input logic [7:0] c, input logic [7:0] a,
                                           input logic [31:0] d);
    logic [7:0] b;
    if (i == n - 4'd1) b = 8'h55;
    else begin
      case (i)
        4'd0:    b = 8'hAA;
        4'd1:    b = c;
        4'd2:    b = a;
        4'd3:    b = d[31:24];
        4'd4:    b = d[23:16];
        4'd5:    b = d[15:8];
        default: b = d[7:0];
      endcase
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      rx_ready   <= 1'b0;
      wr         <= 1'b0;
      dcnt       <= '0;
      idx        <= '0;
      len        <= '0;
      code       <= '0;
      rdata      <= '0;
`ifdef CMD_BUS_MASTER_TIMEOUT_EN
      tmo        <= '0;
`endif
    end else begin
      cs <= 1'b0;
      we <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_take && rx_data == 8'h55) state <= GET_CMD;
        end
        GET_CMD: if (rx_take) begin
          if (rx_data == 8'h10 || rx_data == 8'h11) begin
            wr    <= rx_data[0];
            state <= GET_ADDR;
          end else begin
            state <= DISCARD;
          end
        end
        GET_ADDR: if (rx_take) begin
          address <= rx_data;
          dcnt    <= '0;
          state   <= wr ? GET_DATA : GET_EOC;
        end
        GET_DATA: if (rx_take) begin
          write_data <= {write_data[23:0], rx_data};
          dcnt       <= dcnt + 2'd1;
          if (dcnt == 2'd3) state <= GET_EOC;
        end
        GET_EOC: if (rx_take) begin
          rx_ready <= 1'b0;
          if (rx_data == 8'hAA) begin
            cs    <= 1'b1;
            we    <= wr;
            state <= BUS_ACCESS;
          end else begin
            code     <= 8'hFD;
            len      <= 4'd3;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= 8'hAA;
            state    <= SEND_RESP;
          end
        end
        DISCARD: if (rx_take && rx_data == 8'hAA) begin
          rx_ready <= 1'b0;
          code     <= 8'hFE;
          len      <= 4'd3;
          idx      <= '0;
          tx_valid <= 1'b1;
          tx_data  <= 8'hAA;
          state    <= SEND_RESP;
        end
        BUS_ACCESS: begin
          rdata    <= read_data;
          code     <= error ? 8'hFC : (wr ? 8'h7E : 8'h7F);
          len      <= (error || wr) ? 4'd4 : 4'd8;
          idx      <= '0;
          tx_valid <= 1'b1;
          tx_data  <= 8'hAA;
          state    <= SEND_RESP;
        end
        SEND_RESP: if (tx_take) begin
          if (idx == len - 4'd1) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
          end else begin
            idx     <= idx + 4'd1;
            tx_data <= resp_byte(idx + 4'd1, len, code, address, rdata);
          end
        end
        default: state <= IDLE;
      endcase

`ifdef CMD_BUS_MASTER_TIMEOUT_EN
      // Overrides the case above only on cycles with no accepted byte, so it never races a transition.
      if (state inside {GET_CMD, GET_ADDR, GET_DATA, GET_EOC, DISCARD}) begin
        if (rx_take) tmo <= '0;
        else if (tmo == TIMEOUT_CYCLES - 1) begin
          tmo   <= '0;
          state <= IDLE;
        end else tmo <= tmo + 32'd1;
      end else begin
        tmo <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmd_bus_master.sv
// Self-checking bench for cmd_bus_master: directed frames plus randomized frames against a frame-level model.
module tb_cmd_bus_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data = '0;
  logic        error = 1'b0;

  always #5 clk = ~clk;

  cmd_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .error(error)
  );

  int total = 0;
  int bad = 0;
  int tx_mode = 0;
  int tx_phase = 0;
  logic [7:0]  tx_q[$];
  logic [40:0] bus_q[$];
  logic        prev_cs = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tx_ready pattern: 0 always ready, 1 random, 2 one cycle on / three off
  initial forever begin
    @(posedge clk); #1;
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      default: begin
        tx_ready = (tx_phase == 0);
        tx_phase = (tx_phase + 1) % 4;
      end
    endcase
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_cs) begin
        chk("first_resp_valid", 64'(tx_valid), 64'd1);
        chk("first_resp_sor", 64'(tx_data), 64'hAA);
      end
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(tx_valid), 64'd1);
        chk("stall_hold_data", 64'(tx_data), 64'(prev_data));
      end
      chk("we_only_with_cs", 64'(we & ~cs), 64'd0);
      if (tx_valid) chk("rx_ready_low_in_resp", 64'(rx_ready), 64'd0);
      if (cs) bus_q.push_back({we, address, write_data});
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      prev_cs    = cs;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_cs    = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // Frame-level reference: locate SOC, decode the command, and list expected bus access and reply bytes.
  function automatic void model(input logic [7:0] f[$], input logic [31:0] rd, input logic e,
                                output logic [7:0] tx[$], output logic [40:0] acc[$]);
    int i = 0;
    logic [7:0]  cmd, addr;
    logic [31:0] wd = '0;
    logic        wrf;
    tx = {};
    acc = {};
    while (i < f.size() && f[i] != 8'h55) i++;
    cmd = f[i+1];
    tx.push_back(8'hAA);
    if (cmd != 8'h10 && cmd != 8'h11) begin
      tx.push_back(8'hFE);
      tx.push_back(8'h55);
      return;
    end
    wrf  = (cmd == 8'h11);
    addr = f[i+2];
    i += 3;
    if (wrf) begin
      for (int k = 0; k < 4; k++) wd = {wd[23:0], f[i+k]};
      i += 4;
    end
    if (f[i] != 8'hAA) begin
      tx.push_back(8'hFD);
      tx.push_back(8'h55);
      return;
    end
    acc.push_back({wrf, addr, wd});
    if (e) begin
      tx.push_back(8'hFC); tx.push_back(addr);
    end else if (wrf) begin
      tx.push_back(8'h7E); tx.push_back(addr);
    end else begin
      tx.push_back(8'h7F); tx.push_back(addr);
      for (int k = 3; k >= 0; k--) tx.push_back(rd[8*k +: 8]);
    end
    tx.push_back(8'h55);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 200);
    if (n >= 200) chk("rx_accept_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input logic [31:0] rd,
                           input logic e, input int mode, input int skip);
    logic [7:0]  etx[$];
    logic [40:0] eacc[$];
    int n = 0;
    model(f, rd, e, etx, eacc);
    read_data = rd;
    error     = e;
    tx_mode   = mode;
    tx_q      = {};
    bus_q     = {};
    for (int k = skip; k < f.size(); k++) send_byte(f[k]);
    while (tx_q.size() < etx.size() && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_resp_wait"}, 64'(n < 1000), 64'd1);
    chk({tag, "_idle_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(rx_ready), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_tx_len"}, 64'(tx_q.size()), 64'(etx.size()));
    for (int k = 0; k < etx.size() && k < tx_q.size(); k++)
      chk($sformatf("%s_tx%0d", tag, k), 64'(tx_q[k]), 64'(etx[k]));
    chk({tag, "_cs_count"}, 64'(bus_q.size()), 64'(eacc.size()));
    if (bus_q.size() == 1 && eacc.size() == 1) begin
      chk({tag, "_we"}, 64'(bus_q[0][40]), 64'(eacc[0][40]));
      chk({tag, "_addr"}, 64'(bus_q[0][39:32]), 64'(eacc[0][39:32]));
      if (eacc[0][40]) chk({tag, "_wdata"}, 64'(bus_q[0][31:0]), 64'(eacc[0][31:0]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs"}, 64'(cs), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_address"}, 64'(address), 64'd0);
    chk({tag, "_wdata"}, 64'(write_data), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] x;
    int kind;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_after_reset", 64'(rx_ready), 64'd1);

    f = {8'h55, 8'h10, 8'h02, 8'hAA};
    run_frame("read", f, 32'h63747431, 1'b0, 0, 0);
    f = {8'h55, 8'h11, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA};
    run_frame("write", f, 32'h0, 1'b0, 0, 0);
    f = {8'h00, 8'h55, 8'h33, 8'h01, 8'h02, 8'hAA};
    run_frame("badcmd", f, 32'h0, 1'b0, 0, 0);
    f = {8'h55, 8'h10, 8'h00, 8'hBB};
    run_frame("bad_eoc", f, 32'h0, 1'b0, 0, 0);
    f = {8'h55, 8'h10, 8'h5A, 8'hAA};
    run_frame("backpressure", f, 32'h12345678, 1'b1, 2, 0);

    bus_q = {};
    tx_q  = {};
    send_byte(8'h55); send_byte(8'h11); send_byte(8'h01);
    reset_n = 1'b0;
    #2;
    check_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_after_mid_reset", 64'(rx_ready), 64'd1);
    chk("mid_reset_no_cs", 64'(bus_q.size()), 64'd0);
    f = {8'h55, 8'h10, 8'h07, 8'hAA};
    run_frame("post_reset_read", f, 32'hCAFEF00D, 1'b0, 0, 0);

`ifdef CMD_BUS_MASTER_TIMEOUT_EN
    tx_q  = {};
    bus_q = {};
    send_byte(8'h55); send_byte(8'h10);
    repeat (16) @(posedge clk);
    #1;
    chk("timeout_no_tx", 64'(tx_q.size()), 64'd0);
    chk("timeout_no_cs", 64'(bus_q.size()), 64'd0);
    f = {8'h55, 8'h10, 8'h03, 8'hAA};
    run_frame("after_timeout", f, 32'h0BADBEEF, 1'b0, 0, 0);
`else
    f = {8'h55, 8'h10, 8'h03, 8'hAA};
    tx_q  = {};
    bus_q = {};
    send_byte(f[0]); send_byte(f[1]);
    repeat (40) @(posedge clk);
    #1;
    chk("stall_no_tx", 64'(tx_q.size()), 64'd0);
    run_frame("long_stall", f, 32'h0BADBEEF, 1'b0, 0, 2);
`endif

    for (int r = 0; r < 25; r++) begin
      f = {};
      repeat ($urandom_range(0, 2)) begin
        x = 8'($urandom);
        if (x == 8'h55) x = 8'h00;
        f.push_back(x);
      end
      f.push_back(8'h55);
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        x = 8'($urandom);
        if (x == 8'h10 || x == 8'h11) x = 8'h12;
        f.push_back(x);
        repeat ($urandom_range(0, 2)) begin
          x = 8'($urandom);
          if (x == 8'hAA) x = 8'h01;
          f.push_back(x);
        end
        f.push_back(8'hAA);
      end else begin
        f.push_back(kind == 1 ? 8'h11 : 8'h10);
        f.push_back(8'($urandom));
        if (kind == 1) repeat (4) f.push_back(8'($urandom));
        if (kind == 2 && $urandom_range(0, 1) == 1) begin
          x = 8'($urandom);
          if (x == 8'hAA) x = 8'hAB;
          f.push_back(x);
        end else f.push_back(8'hAA);
      end
      run_frame($sformatf("rand%0d", r), f, $urandom, 1'($urandom_range(0, 3) == 0),
                $urandom_range(0, 2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
